barrel_shift_arbiter: RTL and testbench
=======================================

# barrel_shift_arbiter

Shares one barrel shifter between R independent requesters. Each requester presents an operand, an amount and a direction over a valid/ready handshake. A round-robin arbiter grants one request per cycle, and the rotated result returns through a single-entry registered output stage tagged with the requester index. The block sits between the instruction/stream sources and `barrel_shifter_top`, which it instantiates as its datapath.

## Interface
- `N`, default 3: log2 of data width. Data width W = 2**N.
- `R`, default 2: number of requesters, R ≥ 2. `IDW` = $clog2(R).
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset_n`, input, 1: one clock; reset is asynchronous and active-low.
- `req_valid`, input, R: request i is presenting an operation.
- `req_ready`, output, R: request i is accepted this cycle. One-hot or zero.
- `req_in`, input, R×W: operand per requester.
- `req_amt`, input, R×N: rotate amount per requester.
- `req_dir`, input, R: 0 = rotate right, 1 = rotate left.
- `out_valid`, output, 1: result register holds a result.
- `out_ready`, input, 1: consumer takes the result this cycle.
- `out_data`, output, W: rotated result.
- `out_id`, output, IDW: index of the requester that produced `out_data`.

## Operation
- States:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- `can_accept` = EMPTY, or (FULL and `out_ready`).
- Arbitration: the grant goes to the first i with `req_valid[i]`, searching from `rr_ptr` upward and wrapping mod R. There is no grant when no request is valid.
- `req_ready[i]` = `can_accept` and grant == i. The block is combinational from `req_valid`, `out_ready` and state; it is never asserted for an invalid request.
- On accept:
  - The granted operands drive `barrel_shifter_top` combinationally.
  - The rotated result (`right_shifted` or `left_shifted` per dir) and the grant index are registered into `out_data`/`out_id`.
  - State → FULL.
  - `rr_ptr` ← (grant+1) mod R.
- FULL, `out_ready`=1, no accept: state → EMPTY. `out_data`/`out_id` hold their last values.
- FULL, `out_ready`=0: all output registers hold. `rr_ptr` holds. `req_ready` = 0.
- Simultaneous drain and accept: the new result replaces the old in the same edge and state stays FULL.
- Rotation semantics:
  - amt = 0 returns the operand unchanged.
  - amt is modulo W by width; no saturation.
- Requesters must hold `req_in`/`req_amt`/`req_dir` stable while `req_valid`=1 and `req_ready`=0. The block does not check this.
- `rr_ptr` only advances on an accepted grant. It wraps from R-1 to 0.
- Reset (asynchronous, any time):
  - `out_valid`=0, `out_data`=0, `out_id`=0, `rr_ptr`=0, state EMPTY.
  - An in-flight result is discarded.
  - `req_ready` = 0 while `reset_n`=0.

## Timing
- Latency: accept edge → `out_valid`=1 on the following cycle, i.e. 1 cycle.
- Throughput: one operation per cycle while `out_ready` stays high.
- No combinational path from `req_*` to `out_*`. `req_ready` depends combinationally on `out_ready`.
- The critical path runs from the grant mux through the shifter (N mux levels) to the output register.

## Structure
- Package `barrel_shift_arb_pkg`:
  - `dir_e` enum (`DIR_RIGHT`=0, `DIR_LEFT`=1).
  - `state_e` enum (`EMPTY`, `FULL`).
- Sub-module `rr_arbiter #(R)`:
  - Inputs: `clk`, `reset_n`, `req` [R], `advance`.
  - Outputs: `grant_oh` [R], `grant_idx` [IDW].
  - Owns `rr_ptr`.
- Top module contains:
  - the operand mux;
  - the `barrel_shifter_top #(.N(N))` instance;
  - the output register/FSM.

## Test plan
- Single requester, N=3: in=8'hD2, amt=3, dir=R → `out_data`=8'h5A, `out_id`=0, one cycle after accept. Same with dir=L → 8'h96. amt=0 → 8'hD2. amt=7 dir=R → 8'hA5.
- Both requesters valid continuously, `out_ready`=1: grants alternate 0,1,0,1. `out_id` follows 0,1,0,1 with no idle cycles.
- Backpressure: `out_ready`=0 for 4 cycles while FULL:
  - `req_ready`=0 throughout;
  - `out_data`/`out_id` stable;
  - on release, the drain and the next accept occur in the same edge.
- Fairness after idle: only req1 valid → grant 1, `rr_ptr`=0. Then both valid → grant 0, then 1.
- Reset mid-operation: assert `reset_n`=0 while FULL with `out_ready`=0:
  - `out_valid`, `out_data` and `out_id` go to 0 immediately (asynchronously);
  - after release, the first grant goes to requester 0.
- Sweep all amt 0..7 × both dirs × random data against a reference rotate model. Scoreboard by `out_id`.

Source files
------------

// File: rtl/barrel_shift_arb_pkg.sv
// rtl/barrel_shift_arb_pkg.sv - shared enums for the barrel shift arbiter
package barrel_shift_arb_pkg;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/barrel_shifter_top.sv
// rtl/barrel_shifter_top.sv - log-depth rotator producing both rotate directions
module barrel_shifter_top #(
  parameter int N = 3
) (
  input  logic [2**N-1:0] in,
  input  logic [N-1:0]    amt,
  output logic [2**N-1:0] right_shifted,
  output logic [2**N-1:0] left_shifted
);

  localparam int W = 2**N;

  logic [W-1:0] rs [N+1];
  logic [W-1:0] ls [N+1];

  assign rs[0] = in;
  assign ls[0] = in;

  // Stage s rotates by 2**s when amt[s] is set; N stages cover every amount.
  for (genvar s = 0; s < N; s++) begin : g_stage
    localparam int SH = 2**s;
    assign rs[s+1] = amt[s] ? {rs[s][SH-1:0], rs[s][W-1:SH]} : rs[s];
    assign ls[s+1] = amt[s] ? {ls[s][W-SH-1:0], ls[s][W-1:W-SH]} : ls[s];
  end

  assign right_shifted = rs[N];
  assign left_shifted  = ls[N];

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search starting at rr_ptr, pointer owner
module rr_arbiter #(
  parameter int R   = 2,
  parameter int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [R-1:0]   req,
  input  logic           advance,
  output logic [R-1:0]   grant_oh,
  output logic [IDW-1:0] grant_idx
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] scan;
  logic           found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = rr_ptr;
    for (int k = 0; k < R; k++) begin
      if (!found && req[scan]) begin
        found           = 1'b1;
        grant_idx       = scan;
        grant_oh[scan]  = 1'b1;
      end
      scan = (scan == IDW'(R-1)) ? '0 : scan + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_idx == IDW'(R-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// rtl/barrel_shift_arbiter.sv - shares one barrel shifter among R requesters
// with round-robin grant and a single-entry tagged result register.
module barrel_shift_arbiter
  import barrel_shift_arb_pkg::*;
#(
  parameter int N   = 3,
  parameter int R   = 2,
  parameter int W   = 2**N,
  parameter int IDW = $clog2(R)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*W-1:0] req_in,
  input  logic [R*N-1:0] req_amt,
  input  logic [R-1:0]   req_dir,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [IDW-1:0] out_id
);

  state_e         state_q, state_d;
  logic [R-1:0]   grant_oh;
  logic [IDW-1:0] grant_idx;
  logic           can_accept;
  logic           accept;
  logic [W-1:0]   in_arr  [R];
  logic [N-1:0]   amt_arr [R];
  logic [W-1:0]   sel_in;
  logic [N-1:0]   sel_amt;
  logic [W-1:0]   rot_r, rot_l, shift_res;

  for (genvar i = 0; i < R; i++) begin : g_unpack
    assign in_arr[i]  = req_in[i*W +: W];
    assign amt_arr[i] = req_amt[i*N +: N];
  end

  // Gating with reset_n keeps req_ready low for the whole reset assertion.
  assign can_accept = reset_n && ((state_q == EMPTY) || out_ready);
  assign accept     = can_accept && (|grant_oh);
  assign req_ready  = grant_oh & {R{can_accept}};

  rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid),
    .advance   (accept),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx)
  );

  assign sel_in  = in_arr[grant_idx];
  assign sel_amt = amt_arr[grant_idx];

  barrel_shifter_top #(.N(N)) u_shift (
    .in            (sel_in),
    .amt           (sel_amt),
    .right_shifted (rot_r),
    .left_shifted  (rot_l)
  );

  assign shift_res = (dir_e'(req_dir[grant_idx]) == DIR_LEFT) ? rot_l : rot_r;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      out_data <= '0;
      out_id   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_data <= shift_res;
        out_id   <= grant_idx;
      end
    end
  end

  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// tb/tb_barrel_shift_arbiter.sv - randomized and directed bench with a
// behavioural rotate/round-robin model for barrel_shift_arbiter.
module tb_barrel_shift_arbiter;

  localparam int N = 3;
  localparam int R = 2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [R-1:0] req_valid = '0;
  logic [R-1:0] req_ready;
  logic [R-1:0] req_dir;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [0:0]   out_id;

  logic [W-1:0] d_in  [R];
  logic [N-1:0] d_amt [R];
  logic         d_dir [R];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < R; i++) begin
      d_in[i] = '0; d_amt[i] = '0; d_dir[i] = 1'b0;
    end
  end

  barrel_shift_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in    ({d_in[1], d_in[0]}),
    .req_amt   ({d_amt[1], d_amt[0]}),
    .req_dir   (req_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  assign req_dir = {d_dir[1], d_dir[0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotation as a window into the operand concatenated with itself.
  function automatic logic [W-1:0] rot(input logic [W-1:0] x, input int a, input logic left);
    logic [2*W-1:0] t;
    if (left) begin
      t = {x, x} << a;
      return t[2*W-1:W];
    end
    t = {x, x} >> a;
    return t[W-1:0];
  endfunction

  // ---------------- behavioural model ----------------
  logic         m_full = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_id = 0;
  int           m_ptr = 0;
  logic         p_acc = 1'b0;
  logic         p_drain = 1'b0;
  int           p_g = 0;
  logic [W-1:0] p_data = '0;

  always @(negedge reset_n) begin
    m_full = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
    p_acc = 1'b0; p_drain = 1'b0;
  end

  always @(negedge clk) begin
    logic         can;
    logic         found;
    int           g;
    logic [R-1:0] exp_ready;
    can = 1'b0; found = 1'b0; g = 0; exp_ready = '0;
    if (reset_n) begin
      can = !m_full || out_ready;
      for (int k = 0; k < R; k++) begin
        if (!found && req_valid[(m_ptr + k) % R]) begin
          found = 1'b1;
          g = (m_ptr + k) % R;
        end
      end
      if (can && found) exp_ready[g] = 1'b1;
    end
    chk("req_ready", req_ready, exp_ready);
    chk("out_valid", out_valid, m_full);
    chk("out_data", out_data, m_data);
    chk("out_id", out_id, m_id);
    p_acc   = can && found;
    p_drain = reset_n && m_full && out_ready;
    p_g     = g;
    p_data  = rot(d_in[g], d_amt[g], d_dir[g]);
  end

  always @(posedge clk) begin
    if (reset_n) begin
      if (p_acc) begin
        m_full = 1'b1; m_data = p_data; m_id = p_g; m_ptr = (p_g + 1) % R;
      end else if (p_drain) begin
        m_full = 1'b0;
      end
    end
    p_acc = 1'b0; p_drain = 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic do_single(input int i, input logic [W-1:0] x, input int a,
                           input logic left, input logic [W-1:0] exp);
    d_in[i] = x; d_amt[i] = N'(a); d_dir[i] = left;
    out_ready = 1'b1;
    req_valid = '0;
    req_valid[i] = 1'b1;
    #1;
    chk("single_ready", req_ready, 1 << i);
    step();
    req_valid = '0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, exp);
    chk("single_id", out_id, i);
    step();
  endtask

  initial begin
    logic [R-1:0] acc;
    logic [W-1:0] x;
    step();
    do_reset();
    step();

    // Directed rotations on requester 0.
    do_single(0, 8'hD2, 3, 1'b0, 8'h5A);
    do_single(0, 8'hD2, 3, 1'b1, 8'h96);
    do_single(0, 8'hD2, 0, 1'b0, 8'hD2);
    do_single(0, 8'hD2, 7, 1'b0, 8'hA5);

    // Both valid, no backpressure: strict alternation with no idle cycles.
    do_reset();
    req_valid = 2'b11;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("alt_valid", out_valid, 1);
      chk("alt_id", out_id, k % 2);
      for (int i = 0; i < R; i++) begin
        d_in[i] = W'($urandom); d_amt[i] = N'($urandom); d_dir[i] = 1'($urandom);
      end
    end

    // Backpressure while FULL, then drain and accept in the same edge.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_ready", req_ready, 0);
      chk("bp_id", out_id, 1);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 2'b01);
    step();
    chk("bp_release_valid", out_valid, 1);
    chk("bp_release_id", out_id, 0);
    req_valid = '0;
    step();

    // Fairness after idle.
    do_reset();
    req_valid = 2'b10;
    step();
    chk("fair_id1", out_id, 1);
    req_valid = 2'b11;
    step();
    chk("fair_id0", out_id, 0);
    step();
    chk("fair_id1b", out_id, 1);
    req_valid = '0;
    step();

    // Asynchronous reset while FULL under backpressure.
    d_in[1] = 8'h3C; d_amt[1] = 3'd1; d_dir[1] = 1'b1;
    req_valid = 2'b10;
    step();
    chk("mid_data", out_data, 8'h78);
    req_valid = '0;
    out_ready = 1'b0;
    step();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_id", out_id, 0);
    chk("arst_ready", req_ready, 0);
    step();
    reset_n = 1'b1;
    req_valid = 2'b11;
    out_ready = 1'b1;
    step();
    chk("post_rst_id", out_id, 0);
    req_valid = '0;
    step();

    // Sweep every amount and direction with random data.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) begin
        int i;
        i = $urandom_range(0, R - 1);
        x = W'($urandom);
        do_single(i, x, a, 1'(d), rot(x, a, 1'(d)));
      end
    end

    // Random traffic with random backpressure; operands held while waiting.
    acc = '1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < R; i++) begin
        if (!req_valid[i] || acc[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          d_in[i]  = W'($urandom);
          d_amt[i] = N'($urandom);
          d_dir[i] = 1'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      acc = req_ready;
      step();
    end

    req_valid = '0;
    out_ready = 1'b1;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
